// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and defaults for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_WIDTH = 6;

endpackage

// File: rtl/gph_cell.sv
// rtl/gph_cell.sv - single-bit generate/propagate/half-sum cell
module gph_cell (
  input  logic x,
  input  logic y,
  output logic g,
  output logic p,
  output logic h
);

  assign g = x & y;
  assign p = x | y;
  assign h = x ^ y;

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - bit-serial add sequencer, one bit per clock, LSB first
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r, ovf_r;
  logic             g, p, h, s, c_next;
  logic             accept, last_bit;

  gph_cell u_cell (
    .x(a_sh[0]),
    .y(b_sh[0]),
    .g(g),
    .p(p),
    .h(h)
  );

  assign s        = h ^ carry;
  assign c_next   = g | (p & carry);
  assign last_bit = (cnt == LAST);

  // in_ready must not depend on in_valid to avoid a combinational handshake loop
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = RUN;
      RUN:  if (last_bit) state_n = DONE;
      DONE: if (out_ready) state_n = in_valid ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      sum_r <= {s, sum_r[WIDTH-1:1]};
      carry <= c_next;
      if (last_bit) begin
        // carry currently held is the one entering the MSB position
        cout_r <= c_next;
        ovf_r  <= carry ^ c_next;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - scoreboard bench for serial_adder_seq
module tb_serial_adder_seq;

  localparam int W = 6;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic rand_or = 0;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    exp_t e;
    t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    return e;
  endfunction

  // Holds in_valid until accepted; pushes expected result on the accept edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input exp_t e, output int acc);
    int n;
    n = 0;
    acc = -1;
    a = ta; b = tb_; cin = tc; in_valid = 1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 0;
        return;
      end
    end
    acc = cyc + 1;
    exp_q.push_back(e);
    acc_q.push_back(acc);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Monitor: latency on each new result, hold stability, scoreboard on handshake
  logic         seen = 0;
  logic [W-1:0] held_s;
  logic         held_c, held_o;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        held_s = sum; held_c = cout; held_o = ovf;
        if (acc_q.size() == 0) check("latency_no_accept", 0, 1);
        else check("latency", cyc - acc_q.pop_front(), W);
      end else begin
        check("hold_sum", sum, held_s);
        check("hold_cout", cout, held_c);
        check("hold_ovf", ovf, held_o);
      end
      if (out_ready) begin
        seen = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.c);
          check("ovf", ovf, e.o);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        check("out_valid_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        acc_q.delete();
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int accs[4];
    logic [W-1:0] ra, rb;
    logic rc;

    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", {cout, ovf, sum}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;

    // basic and wrap/overflow cases
    issue(6'h15, 6'h0A, 0, '{6'h1F, 1'b0, 1'b0}, acc);
    drain();
    issue(6'h3F, 6'h01, 0, '{6'h00, 1'b1, 1'b0}, acc);
    drain();
    issue(6'h1F, 6'h01, 0, '{6'h20, 1'b0, 1'b1}, acc);
    drain();
    issue(6'h20, 6'h20, 1, '{6'h01, 1'b1, 1'b1}, acc);
    drain();

    // backpressure: result held, no new accept while consumer stalls
    out_ready = 0;
    issue(6'h15, 6'h0A, 0, '{6'h1F, 1'b0, 1'b0}, acc);
    wait_valid();
    a = 6'h3F; b = 6'h3F; cin = 1; in_valid = 1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_busy", busy, 0);
    end
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_release", out_valid, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // back-to-back: accepts spaced WIDTH+1 apart
    issue(6'h01, 6'h02, 0, '{6'h03, 1'b0, 1'b0}, accs[0]);
    issue(6'h2A, 6'h15, 1, '{6'h00, 1'b1, 1'b0}, accs[1]);
    issue(6'h10, 6'h10, 0, '{6'h20, 1'b0, 1'b1}, accs[2]);
    issue(6'h3F, 6'h3F, 1, '{6'h3F, 1'b1, 1'b0}, accs[3]);
    for (int i = 1; i < 4; i++) check("b2b_spacing", accs[i] - accs[i-1], W + 1);
    drain();

    // reset during the third RUN cycle discards the operation
    issue(6'h15, 6'h0A, 0, '{6'h1F, 1'b0, 1'b0}, acc);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_outputs", {cout, ovf, sum}, 0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_out_valid", out_valid, 0);
    issue(6'h07, 6'h01, 0, '{6'h08, 1'b0, 1'b0}, acc);
    drain();

    // random operands, gaps and consumer stalls
    rand_or = 1;
    for (int i = 0; i < 200; i++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      rc = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, model(ra, rb, rc), acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rand_or = 0;
    #2 out_ready = 1;
    repeat (3) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
